// File: rtl/vram_arbiter.sv
// vram_arbiter: round-robin sharing of video memory port 1 between requesters A and B.
// Define VRAM_ARBITER_CLEAR_EN to build in the whole-memory clear sequencer.
module vram_arbiter #(
   parameter int unsigned            P_data_bits   = 8,
   parameter int unsigned            P_addr_bits   = 12,
   parameter logic [P_data_bits-1:0] P_clear_value = 8'h20
) (
   input  logic                   I_clock,
   input  logic                   I_reset,
   input  logic                   I_a_req,
   input  logic                   I_a_wren,
   input  logic [P_addr_bits-1:0] I_a_addr,
   input  logic [P_data_bits-1:0] I_a_data,
   output logic                   O_a_ack,
   output logic                   O_a_valid,
   output logic [P_data_bits-1:0] O_a_data,
   input  logic                   I_b_req,
   input  logic                   I_b_wren,
   input  logic [P_addr_bits-1:0] I_b_addr,
   input  logic [P_data_bits-1:0] I_b_data,
   output logic                   O_b_ack,
   output logic                   O_b_valid,
   output logic [P_data_bits-1:0] O_b_data,
   input  logic                   I_clear_start,
   output logic                   O_busy,
   output logic                   O_mem_clock,
   output logic [P_addr_bits-1:0] O_mem_addr,
   output logic                   O_mem_rden,
   output logic                   O_mem_wren,
   output logic [P_data_bits-1:0] O_mem_data,
   input  logic [P_data_bits-1:0] I_mem_data
);

   logic                   grant_a, grant_b;
   logic                   last_b_q, last_b_d;
   logic                   clr_active, clr_issue;
   logic [P_addr_bits-1:0] clr_addr;

   logic [P_addr_bits-1:0] mem_addr_q, mem_addr_d;
   logic [P_data_bits-1:0] mem_data_q, mem_data_d;
   logic                   mem_wren_q, mem_wren_d;
   logic                   mem_rden_q, mem_rden_d;

   // Two-stage read tag: stage 1 tracks the access on the bus, stage 2 the memory output.
   logic                   tag1_rd_q, tag1_b_q;
   logic                   tag2_rd_q, tag2_b_q;

   logic                   a_ack_q, b_ack_q;
   logic                   a_valid_q, a_valid_d;
   logic                   b_valid_q, b_valid_d;
   logic [P_data_bits-1:0] a_data_q, a_data_d;
   logic [P_data_bits-1:0] b_data_q, b_data_d;

`ifdef VRAM_ARBITER_CLEAR_EN
   typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

   clr_state_e             state_q, state_d;
   logic [P_addr_bits-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_issue  = 1'b0;
      case (state_q)
         StIdle: begin
            if (I_clear_start) begin
               state_d    = StClear;
               clr_addr_d = '0;
            end
         end
         StClear: begin
            clr_issue  = 1'b1;
            clr_addr_d = clr_addr_q + {{(P_addr_bits-1){1'b0}}, 1'b1};
            if (&clr_addr_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         state_q    <= StIdle;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign clr_active = (state_q == StClear);
   assign clr_addr   = clr_addr_q;
   assign O_busy     = clr_active;
`else
   logic unused_clear_start;

   assign unused_clear_start = I_clear_start;
   assign clr_active         = 1'b0;
   assign clr_issue          = 1'b0;
   assign clr_addr           = '0;
   assign O_busy             = 1'b0;
`endif

   // A tie goes to whichever requester was not granted last.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!clr_active) begin
         if (I_a_req && I_b_req) begin
            grant_a = last_b_q;
            grant_b = ~last_b_q;
         end else begin
            grant_a = I_a_req;
            grant_b = I_b_req;
         end
      end
   end

   always_comb begin
      last_b_d = last_b_q;
      if (grant_b) begin
         last_b_d = 1'b1;
      end else if (grant_a) begin
         last_b_d = 1'b0;
      end
   end

   always_comb begin
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_wren_d = 1'b0;
      mem_rden_d = 1'b0;
      if (clr_issue) begin
         mem_addr_d = clr_addr;
         mem_data_d = P_clear_value;
         mem_wren_d = 1'b1;
      end else if (grant_a) begin
         mem_addr_d = I_a_addr;
         mem_data_d = I_a_data;
         mem_wren_d = I_a_wren;
         mem_rden_d = ~I_a_wren;
      end else if (grant_b) begin
         mem_addr_d = I_b_addr;
         mem_data_d = I_b_data;
         mem_wren_d = I_b_wren;
         mem_rden_d = ~I_b_wren;
      end
   end

   always_comb begin
      a_valid_d = tag2_rd_q & ~tag2_b_q;
      b_valid_d = tag2_rd_q & tag2_b_q;
      a_data_d  = a_valid_d ? I_mem_data : a_data_q;
      b_data_d  = b_valid_d ? I_mem_data : b_data_q;
   end

   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         last_b_q   <= 1'b1;
         mem_addr_q <= '0;
         mem_data_q <= '0;
         mem_wren_q <= 1'b0;
         mem_rden_q <= 1'b0;
         tag1_rd_q  <= 1'b0;
         tag1_b_q   <= 1'b0;
         tag2_rd_q  <= 1'b0;
         tag2_b_q   <= 1'b0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_valid_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         a_data_q   <= '0;
         b_data_q   <= '0;
      end else begin
         last_b_q   <= last_b_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mem_wren_q <= mem_wren_d;
         mem_rden_q <= mem_rden_d;
         tag1_rd_q  <= mem_rden_d;
         tag1_b_q   <= grant_b;
         tag2_rd_q  <= tag1_rd_q;
         tag2_b_q   <= tag1_b_q;
         a_ack_q    <= grant_a;
         b_ack_q    <= grant_b;
         a_valid_q  <= a_valid_d;
         b_valid_q  <= b_valid_d;
         a_data_q   <= a_data_d;
         b_data_q   <= b_data_d;
      end
   end

   assign O_mem_clock = I_clock;
   assign O_mem_addr  = mem_addr_q;
   assign O_mem_data  = mem_data_q;
   assign O_mem_wren  = mem_wren_q;
   assign O_mem_rden  = mem_rden_q;
   assign O_a_ack     = a_ack_q;
   assign O_b_ack     = b_ack_q;
   assign O_a_valid   = a_valid_q;
   assign O_b_valid   = b_valid_q;
   assign O_a_data    = a_data_q;
   assign O_b_data    = b_data_q;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the second (read/write) port of the 8x4096 video dual-port memory between two requesters: A for CPU writes and B for loader/debug reads and writes.
- The video scanout keeps exclusive use of port 0. This block drives port 1 only.
- Single-cycle accesses, round-robin fairness, registered memory-side outputs.
- Optional built-in clear sequencer fills the whole memory with a constant.

Parameters:
- P_data_bits, 8, memory word width.
- P_addr_bits, 12, memory address width; the memory holds 2^P_addr_bits words.
- P_clear_value, 8'h20, word written by the clear sequencer. Width is P_data_bits.

Ports:
- I_clock  in  1  system clock.
- I_reset  in  1  asynchronous, active-high reset.
- I_a_req  in  1  requester A access request; held until acknowledged.
- I_a_wren  in  1  A: 1 = write, 0 = read. Qualified by I_a_req.
- I_a_addr  in  P_addr_bits  A address.
- I_a_data  in  P_data_bits  A write data.
- O_a_ack  out  1  one-cycle pulse; A's access was issued this cycle.
- O_a_valid  out  1  one-cycle pulse; O_a_data holds A's read result.
- O_a_data  out  P_data_bits  A read data; holds its value between valid pulses.
- I_b_req, I_b_wren, I_b_addr, I_b_data, O_b_ack, O_b_valid, O_b_data  same as the A ports, for requester B.
- I_clear_start  in  1  pulse that starts a clear (effective only with the optional feature).
- O_busy  out  1  a clear is in progress.
- O_mem_clock  out  1  memory port-1 clock; equals I_clock.
- O_mem_addr  out  P_addr_bits  memory address.
- O_mem_rden  out  1  memory read enable.
- O_mem_wren  out  1  memory write enable.
- O_mem_data  out  P_data_bits  memory write data.
- I_mem_data  in  P_data_bits  memory read data; synchronous, one cycle after the address edge.

Behaviour:
- Reset (asynchronous):
  - All O_* outputs except O_mem_clock go to 0.
  - Round-robin pointer favours A.
  - Read-return pipeline flushed; no valid pulse follows reset.
  - Clear sequencer returns to IDLE.
- Arbitration is evaluated every cycle from the registered input state:
  - Only one of A or B requesting: that requester is granted.
  - Both requesting: grant goes to the one not granted last.
  - Pointer updates on every grant.
  - Maximum throughput is one access per cycle.
  - A requester waits at most one other grant.
- Grant at edge t:
  - O_mem_addr, O_mem_wren, O_mem_rden and O_mem_data are registered from the winner and valid after edge t.
  - O_x_ack is high for the cycle after edge t.
  - O_mem_rden = ~wren; O_mem_wren = wren.
  - With no grant, both enables are 0; address and data hold their last value.
- Requester handshake:
  - Requester keeps req, addr, wren and data stable until it sees ack.
  - If req is still high in the ack cycle, the arbiter treats it as a new request.
  - Back-to-back accesses by one requester are allowed when the other is idle.
- Read latency:
  - Memory samples at edge t+1; I_mem_data is captured into O_x_data at edge t+2.
  - O_x_valid pulses after edge t+2, so valid follows ack by 2 cycles.
  - A 2-deep tag pipeline (owner, is_read) routes returned data to the correct requester; interleaved A/B reads return in issue order.
  - Writes produce no valid pulse.
- Write then read of the same address in consecutive grants returns the new data (memory is read-after-write at distinct edges).

Optional Feature:
- Macro VRAM_ARBITER_CLEAR_EN.
- Defined:
  - Clear FSM with states IDLE and CLEAR.
  - An I_clear_start pulse in IDLE enters CLEAR at the next edge and sets O_busy.
  - In CLEAR, one write of P_clear_value per cycle to addresses 0 .. 2^P_addr_bits-1 ascending. This has absolute priority: no acks, requests stay pending.
  - After the last address is issued: O_busy clears and the FSM returns to IDLE the next cycle. Arbitration resumes with the pointer unchanged.
  - I_clear_start during CLEAR is ignored.
  - Reads already in flight when CLEAR begins still return their valid pulses.
  - Reset mid-clear aborts it; no further writes.
- Not defined: I_clear_start is ignored, O_busy is constant 0, and no clear logic is synthesised.

Test Plan:
- Reset then idle: all outputs 0, O_mem_rden = O_mem_wren = 0 for 10 cycles; reset mid-read produces no O_a_valid.
- A writes 8'h41 to 12'h005, then reads 12'h005: O_a_ack on each access; O_a_valid exactly 2 cycles after the read ack with O_a_data = 8'h41; B outputs silent.
- A and B both hold req for 6 cycles (reads of 12'h010 and 12'h020 preloaded 8'h11/8'h22): grants alternate A,B,A,B,A,B; O_a_data = 8'h11, O_b_data = 8'h22, each valid lands 2 cycles after its ack.
- B alone holds req continuously with 4 distinct writes: 4 consecutive acks, one per cycle; memory contents verified via port-0 model.
- VRAM_ARBITER_CLEAR_EN: I_clear_start pulse, then A requests during the clear: O_busy high for 4096 cycles, every address reads 8'h20 afterwards, A ack comes the first cycle after O_busy falls.
- VRAM_ARBITER_CLEAR_EN: reset asserted at clear address 12'h100: O_busy = 0 at once, no further O_mem_wren, addresses 12'h100 and above keep their old data.
